// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, rcon, GF(2^8) helpers, block type.
// The decryption path adds its inverse tables here.
package aes_pkg;

   localparam logic [3:0] NUM_ROUNDS = 4'd10;

   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } enc_fsm_e;

   // Byte 0x00 occupies the top byte, byte 0xff the bottom byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return SBOX_TBL[idx +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One forward AES round, purely combinational.
// Bytes are column-major: byte i is row i%4, column i/4.
module aes_enc_round
   import aes_pkg::*;
(
   input  block_t state_in,
   input  block_t round_key,
   input  logic   last,
   output block_t state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         sb[i] = sbox(state_in[127-8*i -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[r+4*c] = sb[r+4*((c+r)%4)];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = gf_mul2(sr[4*c]) ^ gf_mul3(sr[4*c+1])
                   ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ gf_mul2(sr[4*c+1])
                   ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1]
                   ^ gf_mul2(sr[4*c+2]) ^ gf_mul3(sr[4*c+3]);
         mc[4*c+3] = gf_mul3(sr[4*c]) ^ sr[4*c+1]
                   ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
      end
      state_out = '0;
      for (int i = 0; i < 16; i++) begin
         state_out[127-8*i -: 8] = (last ? sr[i] : mc[i])
                                 ^ round_key[127-8*i -: 8];
      end
   end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock,
// round keys expanded on the fly alongside the data.
module aes_enc_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         ready,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic [127:0] data_out,
   output logic         done
);

   enc_fsm_e   fsm_q, fsm_d;
   block_t     state_q, state_d;
   block_t     rk_q, rk_d;
   block_t     dout_q, dout_d;
   logic [3:0] round_q, round_d;

   logic [31:0] w0, w1, w2, w3, tw;
   logic [31:0] n0, n1, n2, n3;
   block_t      kr;
   block_t      round_out;
   logic        last;
   logic        round_ok;
   logic        accept;

   assign w0 = rk_q[127:96];
   assign w1 = rk_q[95:64];
   assign w2 = rk_q[63:32];
   assign w3 = rk_q[31:0];
   assign tw = sub_word({w3[23:0], w3[31:24]})
             ^ {rcon(round_q), 24'h0};
   assign n0 = w0 ^ tw;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign kr = {n0, n1, n2, n3};

   assign last     = (round_q == NUM_ROUNDS);
   assign round_ok = (round_q != 4'd0) && (round_q <= NUM_ROUNDS);

   aes_enc_round u_round (
      .state_in  (state_q),
      .round_key (kr),
      .last      (last),
      .state_out (round_out)
   );

   assign ready    = (fsm_q != S_RUN);
   assign done     = (fsm_q == S_DONE);
   assign accept   = start && ready;
   assign data_out = dout_q;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      dout_d  = dout_q;
      unique case (fsm_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = data_in ^ key_in;
               rk_d    = key_in;
               round_d = 4'd1;
               fsm_d   = S_RUN;
            end else begin
               fsm_d   = S_IDLE;
            end
         end
         S_RUN: begin
            if (round_ok) begin
               state_d = round_out;
               rk_d    = kr;
               round_d = round_q + 4'd1;
               if (last) begin
                  dout_d = round_out;
                  fsm_d  = S_DONE;
               end
            end else begin
               fsm_d = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= S_IDLE;
         state_q <= '0;
         rk_q    <= '0;
         round_q <= '0;
         dout_q  <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         dout_q  <= dout_d;
      end
   end

endmodule
